// File: rtl/led_chaser_sequencer.sv
// led_chaser_sequencer: prescaled 8-bit LED chaser controller (right/left/bounce/fill); bounce mode enabled by SEQ_BOUNCE_EN
module led_chaser_sequencer #(
    parameter int NBITS_OUTPUT = 8,
    parameter int NBITS_RATE   = 4,
    parameter int NBITS_STEP   = 8
) (
    input  logic                    clk_2,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    freeze,
    input  logic [1:0]              mode,
    input  logic [NBITS_RATE-1:0]   rate,
    output logic [NBITS_OUTPUT-1:0] LED,
    output logic                    busy,
    output logic                    wrap,
    output logic [NBITS_STEP-1:0]   step_count
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [NBITS_OUTPUT-1:0] MSB  = {1'b1, {(NBITS_OUTPUT-1){1'b0}}};
    localparam logic [NBITS_OUTPUT-1:0] LSB  = {{(NBITS_OUTPUT-1){1'b0}}, 1'b1};
    localparam logic [NBITS_OUTPUT-1:0] ONES = '1;
    localparam logic [NBITS_OUTPUT-1:0] NEAR_MSB = MSB >> 1;
    state_t                  state_q;
    logic [NBITS_OUTPUT-1:0] led_q, pat_d, start_pat, shift_pat;
    logic [NBITS_RATE-1:0]   cnt_q;
    logic [NBITS_STEP-1:0]   step_q;
    logic [1:0]              mode_q, mode_d;
    logic                    busy_q, wrap_q, wrap_d, tick, go_left, is_fill;
`ifdef SEQ_BOUNCE_EN
    logic                    dir_q, dir_d, bounce;
`endif
    // next pattern for an advance tick: shift direction, wrap detection and reload on wrap
    always_comb begin
        tick      = cnt_q >= rate;
        start_pat = (mode == 2'b01) ? LSB : MSB;
        is_fill   = mode_q == 2'b11;
        go_left   = mode_q == 2'b01;
        wrap_d    = is_fill ? led_q == ONES : go_left ? led_q == MSB : led_q == LSB;
`ifdef SEQ_BOUNCE_EN
        bounce    = mode_q == 2'b10;
        go_left   = bounce ? (dir_q || led_q == LSB) : go_left;
        wrap_d    = bounce ? (dir_q && led_q == NEAR_MSB) : wrap_d;
        dir_d     = wrap_d ? 1'b0 : (bounce && go_left);
`endif
        shift_pat = is_fill ? {1'b1, led_q[NBITS_OUTPUT-1:1]} : go_left ? led_q << 1 : led_q >> 1;
        pat_d     = wrap_d ? start_pat : shift_pat;
        mode_d    = wrap_d ? mode : mode_q;
    end
    // phase sequencing with registered outputs; stop beats freeze beats tick
    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
            led_q   <= '0;
            cnt_q   <= '0;
            step_q  <= '0;
            mode_q  <= 2'b00;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef SEQ_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: if (start && !stop) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                    mode_q  <= mode;
                    led_q   <= start_pat;
                    cnt_q   <= '0;
                    step_q  <= '0;
`ifdef SEQ_BOUNCE_EN
                    dir_q   <= 1'b0;
`endif
                end
                RUN: if (stop) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    led_q   <= '0;
                end else if (freeze) begin
                    state_q <= HOLD;
                end else if (tick) begin
                    cnt_q  <= '0;
                    step_q <= step_q + 1'b1;
                    led_q  <= pat_d;
                    wrap_q <= wrap_d;
                    mode_q <= mode_d;
`ifdef SEQ_BOUNCE_EN
                    dir_q  <= dir_d;
`endif
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                HOLD: if (stop) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    led_q   <= '0;
                end else if (!freeze) begin
                    state_q <= RUN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign LED        = led_q;
    assign busy       = busy_q;
    assign wrap       = wrap_q;
    assign step_count = step_q;
endmodule

// File: tb/tb_led_chaser_sequencer.sv
// tb_led_chaser_sequencer: scoreboard bench with a sequence-table reference model
module tb_led_chaser_sequencer;
    logic       clk_2, reset, start, stop, freeze;
    logic [1:0] mode;
    logic [3:0] rate;
    logic [7:0] LED, step_count;
    logic       busy, wrap;

    led_chaser_sequencer dut (
        .clk_2(clk_2), .reset(reset), .start(start), .stop(stop), .freeze(freeze),
        .mode(mode), .rate(rate), .LED(LED), .busy(busy), .wrap(wrap), .step_count(step_count)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

`ifdef SEQ_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] led;
        logic       busy;
        logic       wrap;
        logic [7:0] step;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;

    // reference model: position within a per-mode sweep table
    bit         m_busy, m_hold, m_wrap;
    logic [1:0] m_mode;
    int         m_idx, m_cnt;
    logic [7:0] m_step;

    function automatic int seq_len(logic [1:0] m);
        return (m == 2'b10 && BOUNCE) ? 14 : 8;
    endfunction

    function automatic logic [7:0] seq_val(logic [1:0] m, int i);
        logic [7:0] r, l, f;
        r = 8'h80;
        l = 8'h01;
        f = 8'hFF;
        if (m == 2'b01) return l << i;
        if (m == 2'b11) return f << (7 - i);
        if (m == 2'b10 && BOUNCE && i >= 8) return l << (i - 7);
        return r >> i;
    endfunction

    function automatic void model_step();
        if (reset) begin
            m_busy = 0; m_hold = 0; m_wrap = 0; m_mode = 2'b00;
            m_idx = 0; m_cnt = 0; m_step = 8'h00;
            return;
        end
        m_wrap = 0;
        if (!m_busy) begin
            if (start && !stop) begin
                m_busy = 1; m_hold = 0; m_mode = mode; m_idx = 0; m_cnt = 0; m_step = 8'h00;
            end
        end else if (stop) begin
            m_busy = 0; m_hold = 0;
        end else if (m_hold) begin
            m_hold = freeze;
        end else if (freeze) begin
            m_hold = 1;
        end else if (m_cnt >= int'(rate)) begin
            m_cnt = 0;
            m_step = m_step + 8'd1;
            m_idx = m_idx + 1;
            if (m_idx == seq_len(m_mode)) begin
                m_idx = 0;
                m_mode = mode;
                m_wrap = 1;
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
    endfunction

    task automatic cyc(input logic r, input logic s, input logic p, input logic f,
                       input logic [1:0] m, input logic [3:0] rt);
        exp_t x;
        reset = r; start = s; stop = p; freeze = f; mode = m; rate = rt;
        model_step();
        x.led  = m_busy ? seq_val(m_mode, m_idx) : 8'h00;
        x.busy = m_busy;
        x.wrap = m_wrap;
        x.step = m_step;
        sb.push_back(x);
        @(posedge clk_2);
        #1;
    endtask

    task automatic run(input int n, input logic [1:0] m, input logic [3:0] rt);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, m, rt);
    endtask

    function automatic void chk(string n, logic [7:0] a, logic [7:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", n, a, x, $time);
        end
    endfunction

    // monitor: DUT presents a fresh registered output every cycle; compare away from the edge
    always @(negedge clk_2) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("LED", LED, e.led);
            chk("busy", {7'd0, busy}, {7'd0, e.busy});
            chk("wrap", {7'd0, wrap}, {7'd0, e.wrap});
            chk("step_count", step_count, e.step);
        end
    end

    initial begin
        reset = 1; start = 0; stop = 0; freeze = 0; mode = 0; rate = 0;
        cyc(1, 0, 0, 0, 2'b00, 4'd0);
        cyc(1, 0, 0, 0, 2'b00, 4'd0);
        cyc(0, 0, 0, 0, 2'b00, 4'd0);
        // right sweep at full speed with wrap
        cyc(0, 1, 0, 0, 2'b00, 4'd0);
        run(12, 2'b00, 4'd0);
        cyc(0, 0, 1, 0, 2'b00, 4'd0);
        // left with prescaler 3
        cyc(0, 1, 0, 0, 2'b01, 4'd3);
        run(40, 2'b01, 4'd3);
        cyc(0, 0, 1, 0, 2'b01, 4'd3);
        // bounce (or right without the feature)
        cyc(0, 1, 0, 0, 2'b10, 4'd0);
        run(32, 2'b10, 4'd0);
        cyc(0, 0, 1, 0, 2'b10, 4'd0);
        // freeze at 0x10 for 5 cycles
        cyc(0, 1, 0, 0, 2'b00, 4'd0);
        run(3, 2'b00, 4'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 2'b00, 4'd0);
        run(4, 2'b00, 4'd0);
        cyc(0, 0, 1, 0, 2'b00, 4'd0);
        // mode change mid-sweep takes effect at the next wrap
        cyc(0, 1, 0, 0, 2'b00, 4'd0);
        run(2, 2'b00, 4'd0);
        run(20, 2'b11, 4'd0);
        // stop together with freeze, then reset mid-run
        cyc(0, 0, 1, 1, 2'b11, 4'd0);
        run(2, 2'b00, 4'd0);
        cyc(0, 1, 1, 0, 2'b00, 4'd0);
        cyc(0, 1, 0, 0, 2'b00, 4'd2);
        run(5, 2'b00, 4'd2);
        cyc(1, 0, 0, 0, 2'b00, 4'd2);
        run(2, 2'b00, 4'd2);
        // step_count rollover and slowest rate
        cyc(0, 1, 0, 0, 2'b00, 4'd0);
        run(260, 2'b00, 4'd0);
        run(40, 2'b00, 4'd15);
        cyc(0, 0, 1, 0, 2'b00, 4'd0);
        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2)));
        end
        cyc(0, 0, 0, 0, 2'b00, 4'd0);
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk_2);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_chaser_sequencer.md
Name: led_chaser_sequencer

Overview:
Controller for the 8-bit LED chaser datapath. It schedules when the one-hot/fill pattern register advances, using a programmable prescaler. It sequences run, hold and idle phases and selects the travel pattern (right, left, bounce, fill). It sits between the switch inputs and the LED outputs of the top-level board wrapper.

Parameters:
NBITS_OUTPUT, 8, width of LED pattern register
NBITS_RATE, 4, width of prescaler reload value
NBITS_STEP, 8, width of step counter

Ports:
clk_2  input  1  board clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level; begins a run when sampled high in IDLE
stop  input  1  level; aborts run, returns to IDLE
freeze  input  1  level; holds pattern and prescaler while high
mode  input  2  00 right, 01 left, 10 bounce, 11 fill
rate  input  NBITS_RATE  pattern advances every rate+1 cycles
LED  output  NBITS_OUTPUT  current pattern
busy  output  1  high in RUN or HOLD
wrap  output  1  one-cycle pulse when pattern returns to its start value
step_count  output  NBITS_STEP  advances since last start, modulo 2^NBITS_STEP

Behaviour:
- Reset (sync, active-high, highest priority): state IDLE, LED=0, prescaler cnt=0, busy=0, wrap=0, step_count=0, dir=right, latched mode=00.
- States: IDLE, RUN, HOLD. All outputs are registered.
- IDLE: LED=0. start=1 and stop=0 -> RUN. Latch mode. Load start pattern: 0x80 for right, bounce and fill; 0x01 for left. Set cnt=0 and step_count=0. The pattern appears on LED the cycle after the start edge.
- RUN: cnt increments each cycle. Tick when cnt>=rate; on a tick, cnt<=0. Using >= means a live rate decrease never stalls the chaser.
- On a tick, step_count increments and the pattern advances:
  - right: LED>>1; after 0x01 reload 0x80 and pulse wrap.
  - left: LED<<1; after 0x80 reload 0x01 and pulse wrap.
  - bounce: moves right from 0x80; at 0x01 dir flips to left; at 0x80 dir flips to right and wrap pulses. End values are not repeated, so the sequence is ...0x02,0x01,0x02...
  - fill: LED<={1,LED[7:1]}; after 0xFF reload 0x80 and pulse wrap.
- Mode change: mode is latched only at start and on each wrap tick. On a wrap tick, the reload value is the start pattern of the newly sampled mode, and dir is reset to right. A mode change mid-sweep takes effect at the next wrap.
- rate is sampled live every cycle.
- wrap is high exactly one cycle, coincident with the reloaded LED value.
- RUN and freeze=1 -> HOLD next cycle. The tick is suppressed in that cycle; LED and cnt are frozen.
- HOLD and freeze=0 -> RUN. cnt resumes from its held value, with no extra tick.
- stop=1 in RUN or HOLD -> IDLE next cycle: LED=0, busy=0, and step_count keeps its value.
- Priority: reset > stop > freeze > tick. start and stop high together in IDLE: stay IDLE. start in RUN/HOLD is ignored.
- rate=0: advance every cycle.
- step_count wraps from 0xFF to 0x00 silently.

Optional Feature:
Macro SEQ_BOUNCE_EN.
- Defined: mode 10 behaves as bounce, as above.
- Undefined: bounce logic and the dir register are omitted, and mode 10 behaves identically to mode 00 (right).

Test Plan:
- reset=1 for 2 cycles, then start=1, mode=00, rate=0 -> LED 0x80,0x40,…,0x01,0x80 on consecutive cycles; wrap high with the second 0x80; busy=1.
- mode=01, rate=3, start -> LED 0x01 held for 4 cycles, then 0x02; step_count=1 after the first advance.
- mode=10, rate=0 (SEQ_BOUNCE_EN defined) -> 0x80…0x01,0x02…0x80; wrap high only at the return to 0x80. With the macro undefined -> same sequence as mode 00.
- Running at rate=0, LED=0x10, freeze=1 for 5 cycles -> LED stays 0x10 and busy=1. freeze=0 -> 0x08 on the next tick.
- Mid-sweep at LED=0x20, mode changed 00->11 -> right sweep continues to 0x01; wrap reloads 0x80 and then fill gives 0xC0,0xE0…0xFF.
- Running, stop=1 together with freeze=1 -> IDLE, LED=0, busy=0. Later, reset=1 mid-run -> all outputs 0 on the next edge.
